// File: rtl/data_mem_arbiter_pkg.sv
// Shared defaults and requester naming for the data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int unsigned DATA_W_DEFAULT    = 32;
    localparam int unsigned ADDR_W_DEFAULT    = 10;
    localparam int unsigned MAX_BURST_DEFAULT = 8;

    // Requester index: core MEM stage and program loader.
    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_idx_t;

endpackage

// File: rtl/data_mem_arbiter_rr_grant2.sv
// Two-requester grant logic: round-robin when unlocked, holds the owner
// while a locked burst is running, forces a handoff once the burst limit
// is reached and the other side is waiting.
// Ports:
//   req        per-requester request
//   owner      last granted requester
//   locked     owner currently holds a burst lock
//   burst_cnt  consecutive locked grants to owner
//   gnt        one-hot grant (combinational)
module rr_grant2
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       req,
    input  logic             owner,
    input  logic             locked,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       gnt
);

    logic other;
    logic burst_full;

    assign other      = ~owner;
    assign burst_full = (burst_cnt == CNT_W'(MAX_BURST));

    // Grant selection
    always_comb begin
        gnt = 2'b00;
        if (locked && req[owner]) begin
            if (burst_full && req[other]) begin
                gnt[other] = 1'b1;
            end else begin
                gnt[owner] = 1'b1;
            end
        end else if (req == 2'b11) begin
            gnt[other] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates one single-port synchronous-read data memory between the core
// MEM stage (requester 0) and the loader (requester 1). One access per cycle,
// combinational grant and memory mux, read data returned one cycle later.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_i, lock_i, we_i         per-requester request, burst lock, write enable
//   addr_i, wdata_i             per-requester word address and write data
//   gnt_o                       one-hot grant (combinational)
//   rvalid_o, rdata_o           read return, rdata_o is mem_rdata_i directly
//   mem_en_o, mem_we_o          memory strobe and write enable
//   mem_addr_o, mem_wdata_o     memory address and write data
//   mem_rdata_i                 memory read data (one cycle after strobe)
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             lock_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic [DATA_W-1:0]      mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    req_idx_t         owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       rvalid_q;

    logic [1:0]       gnt_raw;
    req_idx_t         gnt_idx;
    logic             forced_handoff;
    logic [CNT_W-1:0] cnt_base;

    rr_grant2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_rr_grant2 (
        .req       (req_i),
        .owner     (owner_q),
        .locked    (locked_q),
        .burst_cnt (burst_cnt_q),
        .gnt       (gnt_raw)
    );

    // Grant is suppressed during reset regardless of requests
    assign gnt_o   = rst ? 2'b00 : gnt_raw;
    assign gnt_idx = gnt_o[1] ? REQ_LOADER : REQ_CORE;

    // Memory port mux, all zero when nobody is granted
    always_comb begin
        mem_en_o    = |gnt_o;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_en_o) begin
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_i[gnt_idx];
            mem_wdata_o = wdata_i[gnt_idx];
        end
    end

    // A handoff forced by burst exhaustion starts the new owner unlocked
    assign forced_handoff = locked_q && req_i[owner_q] && (gnt_idx != owner_q);
    // Count only continues for the same owner; a new owner restarts at zero
    assign cnt_base       = (gnt_idx == owner_q) ? burst_cnt_q : '0;

    // Arbiter next state
    always_comb begin
        owner_d     = owner_q;
        locked_d    = 1'b0;
        burst_cnt_d = '0;
        if (mem_en_o) begin
            owner_d = gnt_idx;
            if (lock_i[gnt_idx] && !forced_handoff) begin
                locked_d    = 1'b1;
                burst_cnt_d = (cnt_base == CNT_W'(MAX_BURST)) ? cnt_base
                                                             : cnt_base + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= REQ_LOADER;
            locked_q    <= 1'b0;
            burst_cnt_q <= '0;
            rvalid_q    <= 2'b00;
        end else begin
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= gnt_o & ~we_i;
        end
    end

    // A read granted just before reset must not surface while rst is high
    assign rvalid_o = rst ? 2'b00 : rvalid_q;
    assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;

    logic                   clk;
    logic                   rst;
    logic [1:0]             req;
    logic [1:0]             lock;
    logic [1:0]             we;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             gnt_o;
    logic [1:0]             rvalid_o;
    logic [DATA_W-1:0]      rdata_o;
    logic                   mem_en_o;
    logic                   mem_we_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_wdata_o;
    logic [DATA_W-1:0]      mem_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] env_mem [MEM_WORDS];
    logic [DATA_W-1:0] shadow  [MEM_WORDS];

    data_mem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return DATA_W'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Synchronous-read memory driven by the DUT memory port
    initial begin : env
        for (int i = 0; i < int'(MEM_WORDS); i++) env_mem[i] = init_word(i);
        env_mem[5] = 32'hDEAD_BEEF;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            if (mem_en_o) begin
                if (mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
                else          mem_rdata_i <= env_mem[mem_addr_o];
            end
        end
    end

    // Reference model and per-cycle compare
    initial begin : cmp
        int          last;
        bit          in_burst;
        int          blen;
        int          w;
        bit          forced;
        logic [1:0]  pend_rv;
        logic [31:0] pend_data;
        logic [1:0]  exp_g;

        last = 1; in_burst = 0; blen = 0; pend_rv = 2'b00; pend_data = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) shadow[i] = init_word(i);
        shadow[5] = 32'hDEAD_BEEF;

        forever begin
            @(negedge clk);
            chk("rvalid", 64'(rvalid_o), 64'(rst ? 2'b00 : pend_rv));
            if (!rst && pend_rv != 2'b00) chk("rdata", 64'(rdata_o), 64'(pend_data));

            // Who should win this cycle
            w = -1;
            if (!rst && req != 2'b00) begin
                if (in_burst && req[last]) begin
                    w = (blen >= int'(MAX_BURST) && req[1-last]) ? 1 - last : last;
                end else if (req == 2'b11) begin
                    w = 1 - last;
                end else begin
                    w = req[0] ? 0 : 1;
                end
            end
            exp_g = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);

            chk("gnt", 64'(gnt_o), 64'(exp_g));
            chk("mem_en", 64'(mem_en_o), 64'(w >= 0));
            if (w >= 0) begin
                chk("mem_we", 64'(mem_we_o), 64'(we[w]));
                chk("mem_addr", 64'(mem_addr_o), 64'(addr[w]));
                if (we[w]) chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata[w]));
            end else begin
                chk("mem_we_idle", 64'(mem_we_o), 64'(0));
                if (rst) begin
                    chk("mem_addr_rst", 64'(mem_addr_o), 64'(0));
                    chk("mem_wdata_rst", 64'(mem_wdata_o), 64'(0));
                end
            end

            // Expected memory effect and read return for next cycle
            pend_rv = 2'b00;
            if (w >= 0) begin
                if (we[w]) shadow[addr[w]] = wdata[w];
                else begin
                    pend_rv[w] = 1'b1;
                    pend_data  = shadow[addr[w]];
                end
            end

            // Burst bookkeeping: length of the current run of locked grants
            if (rst) begin
                last = 1; in_burst = 0; blen = 0;
            end else if (w < 0) begin
                in_burst = 0; blen = 0;
            end else begin
                forced = in_burst && req[last] && (w != last);
                if (lock[w] && !forced) begin
                    blen = (in_burst && w == last) ? ((blen < int'(MAX_BURST)) ? blen + 1 : blen) : 1;
                    in_burst = 1;
                end else begin
                    in_burst = 0; blen = 0;
                end
                last = w;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge
    task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                       input logic [1:0] wr, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d0,
                       input logic [DATA_W-1:0] d1);
        @(posedge clk);
        #1;
        rst = r; req = rq; lock = lk; we = wr;
        addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
        #2;
    endtask

    initial begin : stim
        rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00;
        addr = '0; wdata = '0;

        // Reset holds grant and memory port low even with requests
        cyc(1'b1, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("rst_gnt", 64'(gnt_o), 64'(2'b00));
        chk("rst_mem_en", 64'(mem_en_o), 64'(0));
        chk("rst_rvalid", 64'(rvalid_o), 64'(2'b00));

        // Round robin from reset: 01,10,01,10
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
            chk("rr_seq", 64'(gnt_o), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        end

        // Single read of addr 5
        cyc(1'b0, 2'b01, 2'b00, 2'b00, 10'd5, '0, '0, '0);
        chk("rd5_gnt", 64'(gnt_o), 64'(2'b01));
        chk("rd5_addr", 64'(mem_addr_o), 64'(5));
        cyc(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("rd5_rvalid", 64'(rvalid_o), 64'(2'b01));
        chk("rd5_rdata", 64'(rdata_o), 64'(32'hDEAD_BEEF));

        // Loader locked burst against a waiting core
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 2'b11, 2'b10, 2'b00, 10'd7, 10'd8, '0, '0);
            chk("burst_seq", 64'(gnt_o), 64'((i == 8) ? 2'b01 : 2'b10));
        end

        // Write then read back through the other requester
        cyc(1'b0, 2'b01, 2'b00, 2'b01, 10'd3, '0, 32'h0000_1234, '0);
        chk("wr_gnt", 64'(gnt_o), 64'(2'b01));
        chk("wr_we", 64'(mem_we_o), 64'(1));
        cyc(1'b0, 2'b10, 2'b00, 2'b00, '0, 10'd3, '0, '0);
        chk("wr_no_rvalid", 64'(rvalid_o), 64'(2'b00));
        cyc(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("rb_rvalid", 64'(rvalid_o), 64'(2'b10));
        chk("rb_rdata", 64'(rdata_o), 64'(32'h0000_1234));

        // Locked core drops its request mid-burst
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b01, 2'b01, 2'b00, '0, '0, '0, '0);
        cyc(1'b0, 2'b10, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("drop_gnt", 64'(gnt_o), 64'(2'b10));
        cyc(1'b0, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("drop_unlocked", 64'(gnt_o), 64'(2'b01));

        // Reset right after a granted read
        cyc(1'b0, 2'b10, 2'b00, 2'b00, '0, 10'd5, '0, '0);
        chk("pre_rst_gnt", 64'(gnt_o), 64'(2'b10));
        cyc(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("rst_rvalid_sup", 64'(rvalid_o), 64'(2'b00));
        cyc(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("rst_rvalid_sup2", 64'(rvalid_o), 64'(2'b00));
        cyc(1'b0, 2'b11, 2'b00, 2'b00, '0, '0, '0, '0);
        chk("post_rst_gnt", 64'(gnt_o), 64'(2'b01));

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rq, lk, wr;
            rq[0] = ($urandom_range(0, 3) != 0);
            rq[1] = ($urandom_range(0, 3) != 0);
            lk[0] = ($urandom_range(0, 3) != 0);
            lk[1] = ($urandom_range(0, 3) != 0);
            wr    = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 99) == 0), rq, lk, wr,
                ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)),
                $urandom, $urandom);
        end

        cyc(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width (matches DATA_SIZE).
REQ-002 Parameter ADDR_W, default 10, word address width (2**ADDR_W = MEM_LEN).
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i[1:0]  in  2  per-requester access request (0 = core MEM stage, 1 = loader).
REQ-007 lock_i[1:0]  in  2  per-requester burst lock; keeps ownership while asserted with req.
REQ-008 we_i[1:0]  in  2  per-requester write enable (1 = write, 0 = read).
REQ-009 addr_i[2][ADDR_W]  in  2xADDR_W  per-requester word address.
REQ-010 wdata_i[2][DATA_W]  in  2xDATA_W  per-requester write data.
REQ-011 gnt_o[1:0]  out  2  one-hot grant; request is accepted in the cycle req and gnt are both high.
REQ-012 rvalid_o[1:0]  out  2  read data valid for the named requester.
REQ-013 rdata_o  out  DATA_W  read data, shared by both requesters, qualified by rvalid_o.
REQ-014 mem_en_o  out  1  memory access strobe.
REQ-015 mem_we_o  out  1  memory write enable.
REQ-016 mem_addr_o  out  ADDR_W  memory word address.
REQ-017 mem_wdata_o  out  DATA_W  memory write data.
REQ-018 mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read strobe (synchronous read).

Function
REQ-019 gnt_o SHALL be combinational from req_i and arbiter state, at most one bit high, and zero when req_i == 0.
REQ-020 Memory outputs SHALL mux the granted requester's we/addr/wdata combinationally; mem_en_o = |gnt_o; mem_we_o = 0 when no grant.
REQ-021 Arbiter state: owner (1 bit, last granted), locked (1 bit), burst_cnt (clog2(MAX_BURST+1) bits).
REQ-022 Unlocked arbitration SHALL be round-robin: with both requesting, grant goes to the requester that is not owner; with one requesting, grant goes to it.
REQ-023 On every grant, owner SHALL update to the granted index on the next edge.
REQ-024 Grant with lock_i of the granted requester high SHALL set locked and increment burst_cnt; grant without lock SHALL clear locked and burst_cnt.
REQ-025 While locked and req_i[owner] high, owner SHALL be granted regardless of the other request, until burst_cnt == MAX_BURST.
REQ-026 When burst_cnt == MAX_BURST and the other requester is requesting, the grant SHALL go to the other requester, with locked and burst_cnt cleared; if the other requester is idle, owner keeps the grant and burst_cnt saturates.
REQ-027 Locked owner deasserting req_i SHALL release the lock immediately (same cycle arbitrates unlocked).
REQ-028 A granted read SHALL produce rvalid_o[idx] exactly one cycle later with rdata_o = mem_rdata_i; a granted write SHALL produce no rvalid.
REQ-029 rvalid_o SHALL be at most one-hot and SHALL be driven for every granted read, including back-to-back reads and grant handoffs.
REQ-030 rdata_o SHALL equal mem_rdata_i at all times (no extra register).
REQ-031 Throughput: one access per cycle, no bubble between requesters.

Reset
REQ-032 While rst is high: owner = 1 (so requester 0 wins first contention), locked = 0, burst_cnt = 0, rvalid_o = 0.
REQ-033 gnt_o and memory outputs SHALL be 0 while rst is high, regardless of req_i.
REQ-034 A read granted in the cycle before rst asserts SHALL NOT produce rvalid_o while rst is high.

Structure
REQ-035 DATA_W, ADDR_W defaults, the MAX_BURST constant and a requester-index typedef (REQ_CORE = 0, REQ_LOADER = 1) SHALL live in the shared package.
REQ-036 The block SHALL be one module; the priority/grant logic MAY be a sub-module rr_grant2 (req, owner, locked, burst_cnt -> gnt).

Verification
REQ-037 Only req_i = 01, read addr 5, memory holds 0xDEADBEEF -> gnt_o = 01 that cycle; rvalid_o = 01, rdata_o = 0xDEADBEEF next cycle.
REQ-038 First cycle after reset, req_i = 11 for 4 cycles, no lock -> gnt_o sequence 01, 10, 01, 10.
REQ-039 Requester 1 locked, req_i = 11 held 12 cycles, MAX_BURST = 8 -> gnt_o = 10 for 8 cycles, then 01, then 10 resumes under lock.
REQ-040 Requester 0 writes 0x1234 to addr 3, requester 1 reads addr 3 next cycle -> rvalid_o = 10, rdata_o = 0x1234; no rvalid for the write.
REQ-041 rst asserted one cycle after a granted read -> rvalid_o stays 0; after reset, req_i = 11 -> gnt_o = 01.
REQ-042 Locked requester 0 drops req_i mid-burst with req_i[1] high -> gnt_o = 10 that same cycle; locked cleared.
